// File: rtl/tone_sequencer.sv
// tone_sequencer: steps through a fixed C4..C5 note table, driving the
// half-period divisor and reset of a downstream clock divider. Each note is
// a one-cycle LOAD, NOTE_CYCLES of PLAY and optionally GAP_CYCLES of silence.
// The walk runs from first_note to last_note in either direction, and can loop.
module tone_sequencer #(
    parameter logic [31:0] NOTE_CYCLES = 32'd25_000_000,
    parameter logic [31:0] GAP_CYCLES  = 32'd2_500_000
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        loop_en,
    input  logic [2:0]  first_note,
    input  logic [2:0]  last_note,
    output logic [31:0] count_end,
    output logic        div_reset,
    output logic        busy,
    output logic        done,
    output logic [2:0]  note_idx
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PLAY,
        GAP,
        DONE
    } state_t;

    localparam logic [31:0] NOTE_LAST = NOTE_CYCLES - 32'd1;
    localparam logic [31:0] GAP_LAST  = GAP_CYCLES - 32'd1;

    state_t      state;
    state_t      next_state;
    state_t      adv_state;
    logic [31:0] dur_cnt;
    logic [2:0]  first_q;
    logic [2:0]  last_q;
    logic [2:0]  next_idx;
    logic [2:0]  adv_idx;
    logic        done_q;
    logic        accept;
    logic        play_end;
    logic        gap_end;
    logic        ascending;

    // Half-period divisors for C4..C5 with a 50 MHz clock.
    function automatic logic [31:0] note_value(input logic [2:0] idx);
        logic [31:0] value;
        case (idx)
            3'd0:    value = 32'd95556;
            3'd1:    value = 32'd85131;
            3'd2:    value = 32'd75843;
            3'd3:    value = 32'd71586;
            3'd4:    value = 32'd63776;
            3'd5:    value = 32'd56818;
            3'd6:    value = 32'd50619;
            default: value = 32'd47778;
        endcase
        return value;
    endfunction

    // Qualified start and end-of-duration flags shared by the FSM and datapath.
    always_comb begin
        accept    = ((state == IDLE) || (state == DONE)) && start && !stop;
        play_end  = (state == PLAY) && (dur_cnt == NOTE_LAST);
        gap_end   = (state == GAP) && (dur_cnt == GAP_LAST);
        ascending = (first_q <= last_q);
    end

    // Decide where a finished note goes: step toward last_q, loop, or finish.
    // Stepping direction comes from the latched endpoints, so it never wraps.
    always_comb begin
        adv_state = LOAD;
        adv_idx   = note_idx;
        if (note_idx != last_q) begin
            adv_idx = ascending ? (note_idx + 3'd1) : (note_idx - 3'd1);
        end else if (loop_en) begin
            adv_idx = first_q;
        end else begin
            adv_state = DONE;
        end
    end

    // State register.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and next-index logic; stop beats every other input.
    always_comb begin
        next_state = state;
        next_idx   = note_idx;
        if (stop) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        next_state = LOAD;
                        next_idx   = first_note;
                    end
                end
                LOAD: begin
                    next_state = PLAY;
                end
                PLAY: begin
                    if (play_end) begin
                        if (GAP_CYCLES != 32'd0) begin
                            next_state = GAP;
                        end else begin
                            next_state = adv_state;
                            next_idx   = adv_idx;
                        end
                    end
                end
                GAP: begin
                    if (gap_end) begin
                        next_state = adv_state;
                        next_idx   = adv_idx;
                    end
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    // Datapath: note index, latched endpoints, divisor, duration counter, done pulse.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            note_idx  <= 3'd0;
            first_q   <= 3'd0;
            last_q    <= 3'd0;
            count_end <= 32'd0;
            dur_cnt   <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            note_idx <= next_idx;
            if (accept) begin
                first_q <= first_note;
                last_q  <= last_note;
            end
            if (next_state == LOAD) begin
                count_end <= note_value(next_idx);
            end
            if (next_state != state) begin
                dur_cnt <= 32'd0;
            end else if ((state == PLAY) || (state == GAP)) begin
                dur_cnt <= dur_cnt + 32'd1;
            end
            done_q <= (next_state == DONE) && (state != DONE);
        end
    end

    // Outputs decoded from state; the divider only runs during PLAY.
    always_comb begin
        busy      = (state == LOAD) || (state == PLAY) || (state == GAP);
        div_reset = (state != PLAY);
        done      = done_q;
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: vector table, directed multi-cycle scenarios and randomized
// runs for tone_sequencer. dut_a uses a 2-cycle gap, dut_b no gap; both share inputs.
module tb_tone_sequencer;

    localparam int NOTE = 4;
    localparam int GAPA = 2;

    typedef struct packed {
        logic [31:0] count_end;
        logic        div_reset;
        logic        busy;
        logic        done;
        logic [2:0]  note_idx;
    } out_t;

    typedef struct {
        logic       reset;
        logic       start;
        logic       stop;
        logic       loop_en;
        logic [2:0] first;
        logic [2:0] last;
        out_t       expd;
    } vec_t;

    logic        clock_in = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic [2:0]  first_note = 3'd0;
    logic [2:0]  last_note = 3'd0;
    logic [31:0] a_count_end, b_count_end;
    logic        a_div_reset, b_div_reset;
    logic        a_busy, b_busy;
    logic        a_done, b_done;
    logic [2:0]  a_note_idx, b_note_idx;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   busy_cnt;
    int   done_cnt;
    out_t exp_q[$];
    vec_t vecs[$];

    tone_sequencer #(.NOTE_CYCLES(32'd4), .GAP_CYCLES(32'd2)) dut_a (
        .clock_in(clock_in), .reset(reset), .start(start), .stop(stop),
        .loop_en(loop_en), .first_note(first_note), .last_note(last_note),
        .count_end(a_count_end), .div_reset(a_div_reset), .busy(a_busy),
        .done(a_done), .note_idx(a_note_idx)
    );

    tone_sequencer #(.NOTE_CYCLES(32'd4), .GAP_CYCLES(32'd0)) dut_b (
        .clock_in(clock_in), .reset(reset), .start(start), .stop(stop),
        .loop_en(loop_en), .first_note(first_note), .last_note(last_note),
        .count_end(b_count_end), .div_reset(b_div_reset), .busy(b_busy),
        .done(b_done), .note_idx(b_note_idx)
    );

    always #5 clock_in = ~clock_in;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] tab(input int i);
        case (i)
            0:       return 32'd95556;
            1:       return 32'd85131;
            2:       return 32'd75843;
            3:       return 32'd71586;
            4:       return 32'd63776;
            5:       return 32'd56818;
            6:       return 32'd50619;
            default: return 32'd47778;
        endcase
    endfunction

    function automatic out_t mk(input logic [31:0] c, input logic d, input logic b,
                                input logic dn, input logic [2:0] i);
        out_t o;
        o.count_end = c;
        o.div_reset = d;
        o.busy      = b;
        o.done      = dn;
        o.note_idx  = i;
        return o;
    endfunction

    // Reference: each note is LOAD, NOTE play cycles, gap cycles; walk first->last
    // for the given number of passes, then one done cycle and one resting cycle.
    function automatic void build(input int first, input int last, input int passes, input int gap);
        int step;
        int n;
        int idx;
        exp_q.delete();
        step = (first <= last) ? 1 : -1;
        n = (first <= last) ? (last - first + 1) : (first - last + 1);
        for (int p = 0; p < passes; p++) begin
            for (int k = 0; k < n; k++) begin
                idx = first + k * step;
                exp_q.push_back(mk(tab(idx), 1'b1, 1'b1, 1'b0, idx[2:0]));
                for (int c = 0; c < NOTE; c++) exp_q.push_back(mk(tab(idx), 1'b0, 1'b1, 1'b0, idx[2:0]));
                for (int c = 0; c < gap; c++) exp_q.push_back(mk(tab(idx), 1'b1, 1'b1, 1'b0, idx[2:0]));
            end
        end
        exp_q.push_back(mk(tab(last), 1'b1, 1'b0, 1'b1, last[2:0]));
        exp_q.push_back(mk(tab(last), 1'b1, 1'b0, 1'b0, last[2:0]));
    endfunction

    function automatic out_t sample(input bit use_b);
        if (use_b) return mk(b_count_end, b_div_reset, b_busy, b_done, b_note_idx);
        return mk(a_count_end, a_div_reset, a_busy, a_done, a_note_idx);
    endfunction

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic checkOutput(input string name, input out_t got_in, input out_t exp_in, input bit with_idx);
        out_t got;
        out_t expd;
        got  = got_in;
        expd = exp_in;
        if (!with_idx) begin
            got.note_idx  = 3'd0;
            expd.note_idx = 3'd0;
        end
        n_cmp++;
        if (got !== expd) begin
            n_bad++;
            $display("[TB] FAIL %s: got ce=%0d dr=%b busy=%b done=%b idx=%0d, required ce=%0d dr=%b busy=%b done=%b idx=%0d",
                     name, got.count_end, got.div_reset, got.busy, got.done, got.note_idx,
                     expd.count_end, expd.div_reset, expd.busy, expd.done, expd.note_idx);
        end
    endtask

    task automatic checkCount(input string name, input int got, input int expd);
        n_cmp++;
        if (got != expd) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, got, expd);
        end
    endtask

    task automatic applyReset();
        reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Start a sequence and compare every cycle with the model; optionally drop
    // loop_en after cycle drop_at, or abort with stop/reset during cycle abort_at.
    task automatic applyStimulus(input string name, input bit use_b, input int first, input int last,
                                 input bit loop, input int passes, input int drop_at,
                                 input int abort_at, input bit abort_is_reset);
        out_t got;
        out_t idle_exp;
        build(first, last, passes, use_b ? 0 : GAPA);
        first_note = first[2:0];
        last_note  = last[2:0];
        loop_en    = loop;
        start      = 1'b1;
        busy_cnt   = 0;
        done_cnt   = 0;
        for (int j = 0; j < exp_q.size(); j++) begin
            tick();
            start = 1'b0;
            got = sample(use_b);
            checkOutput(name, got, exp_q[j], 1'b1);
            busy_cnt += int'(got.busy);
            done_cnt += int'(got.done);
            if (j == drop_at) loop_en = 1'b0;
            if (j == abort_at) begin
                if (abort_is_reset) reset = 1'b1;
                else stop = 1'b1;
                tick();
                reset = 1'b0;
                stop  = 1'b0;
                if (abort_is_reset) begin
                    idle_exp = mk(32'd0, 1'b1, 1'b0, 1'b0, 3'd0);
                    checkOutput({name, "_reset"}, sample(use_b), idle_exp, 1'b1);
                end else begin
                    idle_exp = mk(exp_q[j].count_end, 1'b1, 1'b0, 1'b0, 3'd0);
                    checkOutput({name, "_stop"}, sample(use_b), idle_exp, 1'b0);
                end
                tick();
                checkOutput({name, "_after_abort"}, sample(use_b), idle_exp, abort_is_reset);
                break;
            end
        end
    endtask

    initial begin
        // Directed vector table on dut_a: reset, start+stop, single note, start while busy, restart from DONE.
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, mk(32'd0,     1'b1, 1'b0, 1'b0, 3'd0)});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 3'd3, mk(32'd0,     1'b1, 1'b0, 1'b0, 3'd0)});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 3'd4, mk(32'd63776, 1'b1, 1'b1, 1'b0, 3'd4)});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 3'd6, mk(32'd63776, 1'b0, 1'b1, 1'b0, 3'd4)});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, mk(32'd63776, 1'b0, 1'b1, 1'b0, 3'd4)});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, mk(32'd63776, 1'b0, 1'b1, 1'b0, 3'd4)});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, mk(32'd63776, 1'b0, 1'b1, 1'b0, 3'd4)});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, mk(32'd63776, 1'b1, 1'b1, 1'b0, 3'd4)});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, mk(32'd63776, 1'b1, 1'b1, 1'b0, 3'd4)});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, mk(32'd63776, 1'b1, 1'b0, 1'b1, 3'd4)});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, mk(32'd63776, 1'b1, 1'b0, 1'b0, 3'd4)});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 3'd2, mk(32'd75843, 1'b1, 1'b1, 1'b0, 3'd2)});
        for (int i = 0; i < vecs.size(); i++) begin
            reset      = vecs[i].reset;
            start      = vecs[i].start;
            stop       = vecs[i].stop;
            loop_en    = vecs[i].loop_en;
            first_note = vecs[i].first;
            last_note  = vecs[i].last;
            tick();
            checkOutput($sformatf("vec%0d", i), sample(1'b0), vecs[i].expd, 1'b1);
        end

        // Ascending three-note run: 21 busy cycles and exactly one done pulse.
        applyReset();
        applyStimulus("up_0_2", 1'b0, 0, 2, 1'b0, 1, -1, -1, 1'b0);
        checkCount("up_0_2_busy_cycles", busy_cnt, 21);
        checkCount("up_0_2_done_pulses", done_cnt, 1);

        // Descending run 7 -> 5.
        applyReset();
        applyStimulus("down_7_5", 1'b0, 7, 5, 1'b0, 1, -1, -1, 1'b0);

        // Single looping note, loop_en dropped during the third pass.
        applyReset();
        applyStimulus("loop_3", 1'b0, 3, 3, 1'b1, 3, 16, -1, 1'b0);
        checkCount("loop_3_done_pulses", done_cnt, 1);

        // Stop during the second PLAY cycle.
        applyReset();
        applyStimulus("stop_play2", 1'b0, 0, 2, 1'b0, 1, -1, 2, 1'b0);
        checkCount("stop_play2_done_pulses", done_cnt, 0);

        // Reset during the first GAP cycle, then a fresh run.
        applyReset();
        applyStimulus("reset_gap", 1'b0, 1, 3, 1'b0, 1, -1, 5, 1'b1);
        applyStimulus("after_reset", 1'b0, 6, 4, 1'b0, 1, -1, -1, 1'b0);

        // No-gap instance: PLAY straight into LOAD.
        applyReset();
        applyStimulus("nogap_0_1", 1'b1, 0, 1, 1'b0, 1, -1, -1, 1'b0);
        checkCount("nogap_busy_cycles", busy_cnt, 10);

        // Randomized runs on either instance, with occasional stop/reset aborts.
        for (int r = 0; r < 16; r++) begin
            int f;
            int l;
            int mode;
            bit use_b;
            f     = int'($urandom_range(0, 7));
            l     = int'($urandom_range(0, 7));
            mode  = int'($urandom_range(0, 2));
            use_b = 1'($urandom_range(0, 1));
            applyReset();
            applyStimulus($sformatf("rand%0d", r), use_b, f, l, 1'b0, 1, -1,
                          (mode == 0) ? -1 : int'($urandom_range(0, 60)), mode == 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 SHALL have parameter NOTE_CYCLES, default 32'd25_000_000, clock_in cycles each note is held in PLAY (0.5 s at 50 MHz); legal range >= 1.
REQ-002 SHALL have parameter GAP_CYCLES, default 32'd2_500_000, clock_in cycles of silence between notes; 0 means no GAP state is entered.
REQ-003 SHALL have port clock_in, input, 1, system clock (50 MHz); all logic on posedge.
REQ-004 SHALL have port reset, input, 1; reset is synchronous, active-high; clock is clock_in.
REQ-005 SHALL have port start, input, 1, begin sequence; sampled only in IDLE or DONE.
REQ-006 SHALL have port stop, input, 1, abort the sequence; sampled in every state.
REQ-007 SHALL have port loop_en, input, 1, restart the sequence at first_note after last_note, instead of finishing.
REQ-008 SHALL have port first_note, input, 3, start index into the note table; latched on accepted start.
REQ-009 SHALL have port last_note, input, 3, end index into the note table; latched on accepted start.
REQ-010 SHALL have port count_end, output, 32, half-period divisor for the downstream clock divider.
REQ-011 SHALL have port div_reset, output, 1, synchronous reset for the downstream divider (1 = silent or restart).
REQ-012 SHALL have port busy, output, 1, high in LOAD, PLAY and GAP.
REQ-013 SHALL have port done, output, 1, single-cycle pulse when a non-looping sequence completes.
REQ-014 SHALL have port note_idx, output, 3, index of the note currently selected.

Function
REQ-015 SHALL hold a fixed note table, index 0..7 = 95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778 (C4..C5 at 50 MHz).
REQ-016 SHALL implement states IDLE, LOAD, PLAY, GAP and DONE.
REQ-017 IDLE/DONE: when start=1 and stop=0, latch first_note/last_note, set note_idx=first_note, and go to LOAD next cycle.
REQ-018 LOAD lasts exactly 1 cycle: count_end = table[note_idx], div_reset=1, duration counter cleared; next state is PLAY.
REQ-019 PLAY: div_reset=0 and count_end stable; the state lasts exactly NOTE_CYCLES cycles.
REQ-020 At the end of PLAY, go to GAP if GAP_CYCLES>0; otherwise advance directly (REQ-022).
REQ-021 GAP: div_reset=1 and count_end unchanged; the state lasts exactly GAP_CYCLES cycles, then advances.
REQ-022 Advance when note_idx != last_note: step note_idx by +1 if latched first<=last, else by -1; then go to LOAD.
REQ-023 Advance when note_idx == last_note: if loop_en=1, set note_idx=latched first and go to LOAD; otherwise go to DONE with done=1 for exactly that one cycle.
REQ-024 first_note == last_note SHALL play that single note (repeatedly if loop_en=1).
REQ-025 Index stepping SHALL never wrap past 0 or 7; the direction rule of REQ-022 guarantees this.
REQ-026 loop_en SHALL be sampled live at each end-of-sequence decision.
REQ-027 first_note and last_note changes after start SHALL be ignored until the next accepted start.
REQ-028 stop=1 in any state SHALL force IDLE on the next edge with div_reset=1; done SHALL NOT pulse.
REQ-029 stop and start both high SHALL resolve to stop (stop wins).
REQ-030 start while busy SHALL be ignored.
REQ-031 In IDLE and DONE, div_reset=1 and count_end holds its last value.
REQ-032 The duration counter SHALL be 32 bits, compare against (limit-1), and clear on every state entry.

Reset
REQ-033 reset=1 SHALL give: state=IDLE, count_end=0, div_reset=1, busy=0, done=0, note_idx=0, counters=0, latched indices=0.
REQ-034 reset SHALL override start and stop; asserting reset mid-PLAY aborts on the next edge with no done pulse.

Verification (NOTE_CYCLES=4, GAP_CYCLES=2 for sim)
REQ-035 Inputs first=0, last=2, loop=0, start pulse -> count_end sequence 95556, 85131, 75843; each note has 1 LOAD + 4 PLAY + 2 GAP cycles; done pulses once; total busy = 21 cycles.
REQ-036 Inputs first=7, last=5 -> note_idx runs 7, 6, 5, descending, then done.
REQ-037 Inputs first=last=3, loop=1 -> 71586 repeats; drop loop_en mid-note -> done follows after that note's GAP.
REQ-038 Assert stop in the 2nd PLAY cycle -> IDLE next edge, div_reset=1, busy=0, no done; start and stop together in IDLE -> stays IDLE.
REQ-039 Assert reset mid-GAP -> all outputs at REQ-033 values next edge; then a new start works normally.
REQ-040 Use GAP_CYCLES=0 -> the transition goes PLAY to LOAD directly, and div_reset is high exactly 1 cycle between notes.
